// File: rtl/msg_fifo_arbiter.sv
// msg_fifo_arbiter: round-robin arbiter sharing one message FIFO write port
// among NUM_REQ requesters. A granted requester may burst up to MAX_BURST
// 40-bit messages; writes are throttled by the FIFO full flag.
// Optional build macro: MSG_SRC_STAMP_EN -- when defined, the S_ID field
// (bits [23:16]) of every written message is replaced by SRC_BASE + owner.

// Per-requester write gating and message steering.
module msg_fifo_arbiter_lane #(
    parameter int         LANE     = 0,
    parameter logic [7:0] SRC_BASE = 8'h10
) (
    input  logic        reset,
    input  logic        owner,
    input  logic        req,
    input  logic        full,
    input  logic        cnt_ok,
    input  logic [39:0] msg,
    output logic        ack,
    output logic [39:0] msg_out
);

    logic [39:0] msg_sel;

`ifdef MSG_SRC_STAMP_EN
    // Replace S_ID with this lane's source stamp; other fields pass through.
    always_comb begin
        msg_sel = {msg[39:24], SRC_BASE + 8'(LANE), msg[15:0]};
    end
`else
    logic unused_src_base;
    assign unused_src_base = ^SRC_BASE;

    // Message passes through unmodified.
    always_comb begin
        msg_sel = msg;
    end
`endif

    // Accept only for the owner; reset suppresses any write on its edge.
    always_comb begin
        ack     = owner & req & ~full & cnt_ok & ~reset;
        msg_out = ack ? msg_sel : 40'd0;
    end

endmodule

module msg_fifo_arbiter #(
    parameter int         NUM_REQ   = 4,
    parameter int         MAX_BURST = 4,
    parameter logic [7:0] SRC_BASE  = 8'h10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [40*NUM_REQ-1:0] req_msg,
    output logic [NUM_REQ-1:0]    ack,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy,
    input  logic                  fifo_full_flag,
    output logic                  fifo_write_flag,
    output logic [39:0]           fifo_msg
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                    state;
    logic [3:0]                cnt;
    logic [2:0]                last_ptr;

    logic                      win_found;
    logic [2:0]                win_idx;
    logic [2:0]                owner_idx;
    logic                      owner_req;
    logic                      accept;
    logic                      cnt_ok;
    logic [NUM_REQ-1:0][39:0]  msg_in;
    logic [NUM_REQ-1:0][39:0]  lane_msg;

    assign busy   = (state == BURST);
    assign cnt_ok = (cnt < 4'(MAX_BURST));

    // Rotating-priority search starting just after the last owner.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = 3'd0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_ptr) + k) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = 3'(idx);
            end
        end
    end

    // Encode the one-hot owner and pick up its request line.
    always_comb begin
        owner_idx = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) owner_idx = 3'(i);
        end
        owner_req = |(grant & req);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign msg_in[gi] = req_msg[40*gi +: 40];

            msg_fifo_arbiter_lane #(
                .LANE     (gi),
                .SRC_BASE (SRC_BASE)
            ) u_lane (
                .reset   (reset),
                .owner   (grant[gi]),
                .req     (req[gi]),
                .full    (fifo_full_flag),
                .cnt_ok  (cnt_ok),
                .msg     (msg_in[gi]),
                .ack     (ack[gi]),
                .msg_out (lane_msg[gi])
            );
        end
    endgenerate

    // At most one lane is non-zero, so OR-merging steers the owner's message.
    always_comb begin
        fifo_msg = 40'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_msg = fifo_msg | lane_msg[i];
        end
    end

    assign accept          = |ack;
    assign fifo_write_flag = accept;

    // Arbitration / burst FSM with registered grant, burst count and pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            cnt      <= 4'd0;
            last_ptr <= 3'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    // Full flag does not hold off arbitration, only writes.
                    if (win_found) begin
                        grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                        cnt   <= 4'd0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'(MAX_BURST - 1)) begin
                            state    <= IDLE;
                            grant    <= '0;
                            last_ptr <= owner_idx;
                        end
                    end else if (!owner_req) begin
                        // Owner ran dry (possibly while FIFO is full): release.
                        state    <= IDLE;
                        grant    <= '0;
                        last_ptr <= owner_idx;
                    end
                    // Owner requesting with FIFO full: stall, hold everything.
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_fifo_arbiter.sv
// Directed bench for msg_fifo_arbiter (NUM_REQ=4, MAX_BURST=4). A vector
// table covers single-requester bursts and full round-robin rotation;
// hand-written sequences cover reset mid-burst, early release, FIFO stalls
// and owner drop coinciding with full.
module tb_msg_fifo_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [159:0] req_msg;
    logic [3:0]   ack;
    logic [3:0]   grant;
    logic         busy;
    logic         fifo_full_flag;
    logic         fifo_write_flag;
    logic [39:0]  fifo_msg;

    int total = 0;
    int bad   = 0;

    logic [39:0] msgs [4];

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       full;
        logic [3:0] g;
        logic [3:0] a;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    msg_fifo_arbiter #(
        .NUM_REQ   (4),
        .MAX_BURST (4),
        .SRC_BASE  (8'h10)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_msg         (req_msg),
        .ack             (ack),
        .grant           (grant),
        .busy            (busy),
        .fifo_full_flag  (fifo_full_flag),
        .fifo_write_flag (fifo_write_flag),
        .fifo_msg        (fifo_msg)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] exp_msg(input logic [3:0] a);
        logic [39:0] m;
        m = 40'd0;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) begin
                m = msgs[i];
`ifdef MSG_SRC_STAMP_EN
                m[23:16] = 8'h10 + 8'(i);
`endif
            end
        end
        return m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int n, input logic r, input logic [3:0] rq, input logic f,
                       input logic [3:0] g, input logic [3:0] a, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.full = f; v.g = g; v.a = a; v.b = b;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // Drive one cycle of inputs in the low phase and check the outputs.
    task automatic step(input logic r, input logic [3:0] rq, input logic f,
                        input logic [3:0] eg, input logic [3:0] ea, input logic eb,
                        input string nm);
        @(negedge clk);
        reset          = r;
        req            = rq;
        fifo_full_flag = f;
        #1;
        chk({nm, " grant"}, 64'(grant), 64'(eg));
        chk({nm, " ack"},   64'(ack),   64'(ea));
        chk({nm, " busy"},  64'(busy),  64'(eb));
        chk({nm, " wr"},    64'(fifo_write_flag), 64'(|ea));
        chk({nm, " msg"},   64'(fifo_msg), 64'(exp_msg(ea)));
    endtask

    initial begin
        int wr_cnt;
        msgs[0] = 40'h01_A0_00_10_55;
        msgs[1] = 40'h01_A1_01_11_66;
        msgs[2] = 40'h01_A2_FF_22_77;
        msgs[3] = 40'h01_A3_03_33_88;
        req_msg        = {msgs[3], msgs[2], msgs[1], msgs[0]};
        reset          = 1'b1;
        req            = 4'b0000;
        fifo_full_flag = 1'b0;
        repeat (2) @(posedge clk);

        // e0: reset still held; e1..: cycles 0.. after reset release.
        add(1, 1'b1, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add(1, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add(4, 1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1);
        add(1, 1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0);
        // Re-grant to the lone requester, then all four request.
        add(4, 1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1);
        add(1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add(4, 1'b0, 4'b1111, 1'b0, 4'b0010, 4'b0010, 1'b1);
        add(1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add(4, 1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0100, 1'b1);
        add(1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add(4, 1'b0, 4'b1111, 1'b0, 4'b1000, 4'b1000, 1'b1);
        add(1, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0);
        add(1, 1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0001, 1'b1);

        wr_cnt = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].full, tbl[i].g, tbl[i].a, tbl[i].b,
                 $sformatf("vec%0d", i));
            if (i >= 7 && i <= 26 && fifo_write_flag) wr_cnt++;
        end
        chk("rr 20-cycle write count", 64'(wr_cnt), 64'd16);

        // Reset while owner 0 is mid-burst: no write on the reset edge.
        step(1'b1, 4'b1111, 1'b0, 4'b0001, 4'b0000, 1'b1, "rst mid-burst");
        // last_ptr back to 3, so requester 2 wins.
        step(1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, "post-rst idle");
        step(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, "own2 wr1");
        step(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1, "own2 wr2");
        // Owner 2 drops after two accepts; 1011 pending -> 3 is next.
        step(1'b0, 4'b1011, 1'b0, 4'b0100, 4'b0000, 1'b1, "own2 drop");
        step(1'b0, 4'b1011, 1'b0, 4'b0000, 4'b0000, 1'b0, "drop idle");
        step(1'b0, 4'b1011, 1'b0, 4'b1000, 4'b1000, 1'b1, "own3 wr1");
        step(1'b0, 4'b1011, 1'b0, 4'b1000, 4'b1000, 1'b1, "own3 wr2");
        // Reset with owner 3 at cnt=2; first grant afterwards goes to 0.
        step(1'b1, 4'b1001, 1'b0, 4'b1000, 4'b0000, 1'b1, "rst own3");
        step(1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b0, "rst own3 idle");
        step(1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0001, 1'b1, "post-rst own0 wr1");
        step(1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0001, 1'b1, "own0 wr2");
        step(1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0001, 1'b1, "own0 wr3");
        step(1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0001, 1'b1, "own0 wr4");
        // Owner 1 stalls on full for three cycles after one write.
        step(1'b0, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0, "own0 done");
        step(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, "own1 wr1");
        for (int k = 0; k < 3; k++)
            step(1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1, $sformatf("own1 stall%0d", k));
        step(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, "own1 wr2");
        step(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, "own1 wr3");
        step(1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0010, 1'b1, "own1 wr4");
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, "own1 done");
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, "no req idle");
        // Owner drops req in the same cycle the FIFO goes full.
        step(1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, "arb own0");
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, "own0 one wr");
        step(1'b0, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b1, "drop+full");
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, "drop+full idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msg_fifo_arbiter.md
Name: msg_fifo_arbiter

Overview:
- Round-robin arbiter that shares one message FIFO write port among NUM_REQ requesters in the SHA-3 message path.
- Grants one requester at a time and lets it burst up to MAX_BURST 40-bit messages into the FIFO.
- Drives the FIFO write flag and data directly, and throttles on the FIFO full flag.
- Sits between the message producers and the message FIFO's input side.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 4, maximum messages accepted per grant (1..15)
SRC_BASE, 8'h10, S_ID base value used only when MSG_SRC_STAMP_EN is defined

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester request; held high while the requester has a valid message
req_msg  in  40*NUM_REQ  packed messages; slice i = bits [40*i+39:40*i], field order {Al_Dl_101, D_ID, S_ID, M_Addr, M_Data}, 8 bits each
ack  out  NUM_REQ  one-hot; high for a requester in a cycle where its message is written at the next clk edge
grant  out  NUM_REQ  registered one-hot current owner; 0 when idle
busy  out  1  high in BURST state
fifo_full_flag  in  1  FIFO full indication
fifo_write_flag  out  1  FIFO write enable
fifo_msg  out  40  message to FIFO, same field order as req_msg

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset takes priority over all other activity, including mid-burst:
  - state=IDLE, grant=0, cnt=0, last_ptr=NUM_REQ-1.
  - ack, fifo_write_flag and fifo_msg read as 0.
  - No write occurs on the reset edge.
- States: IDLE, BURST.
- IDLE:
  - If req!=0, pick the winner w = first index set in req, scanning last_ptr+1, last_ptr+2, ... modulo NUM_REQ.
  - Next edge: grant<=onehot(w), cnt<=0, state<=BURST.
  - No write happens in IDLE, so there is 1 arbitration cycle of overhead per burst.
  - fifo_full_flag does not block arbitration.
- BURST, with owner g:
  - accept = req[g] & ~fifo_full_flag & (cnt<MAX_BURST). The cnt term is a safety guard.
  - ack[g] = accept; fifo_write_flag = accept. Both are combinational from registered state and inputs.
  - fifo_msg = req_msg slice g when accept, else 0.
  - Requester g advances to its next message the cycle after ack.
  - On accept: cnt<=cnt+1.
  - If accept and cnt==MAX_BURST-1: state<=IDLE, grant<=0, last_ptr<=g.
  - If req[g]==0: state<=IDLE, grant<=0, last_ptr<=g. The burst ends early even if cnt==0.
  - If req[g]==1 and fifo_full_flag==1: hold state, cnt and grant (stall). No timeout.
- Simultaneous events:
  - Requests from non-owners during BURST are ignored until return to IDLE.
  - The owner dropping req on the same cycle the FIFO asserts full ends the burst.
  - The FIFO's full flag reflects committed writes only, so combinational write gating never overflows the FIFO.
- Widths: cnt is 4 bits; last_ptr is 3 bits; pointer arithmetic wraps modulo NUM_REQ.
- Invariants:
  - grant is always one-hot or zero.
  - ack is a subset of grant.
  - fifo_write_flag == |ack.

Optional Feature:
MSG_SRC_STAMP_EN
- Defined: the S_ID field of fifo_msg (bits [23:16]) is replaced with SRC_BASE+g on every write. All other fields pass through unchanged.
- Not defined: fifo_msg is the unmodified req_msg slice, and SRC_BASE is unused.

Test Plan:
- Reset, then req=4'b0001 held with msg0=40'h01_A0_00_10_55 and FIFO never full:
  - grant=0001 at cycle 1.
  - fifo_write_flag high cycles 1..4 (4 writes), then IDLE at cycle 5.
  - Re-grant to 0001 at cycle 6, since it is the only requester.
- req=4'b1111 held continuously:
  - Grants in order 0001, 0010, 0100, 1000, 0001.
  - Each burst is 4 writes; 20 cycles produce 16 writes.
- Owner 2 drops req after 2 accepts:
  - Burst ends with cnt=2, last_ptr=2.
  - With req=4'b1011 pending, the next grant is 1000.
- fifo_full_flag=1 for 3 cycles mid-burst (owner 1, cnt=1):
  - No ack or write during those 3 cycles; grant stays 0010.
  - Writes resume and the burst completes at cnt=4.
- Reset asserted during BURST with owner 3, cnt=2:
  - Next cycle grant=0, fifo_write_flag=0.
  - With req=4'b1001, the first grant after reset is 0001.
- MSG_SRC_STAMP_EN defined, SRC_BASE=8'h10, owner 2, input S_ID=8'hFF:
  - fifo_msg[23:16]=8'h12; the other 32 bits match the input.
